seg_reader: RTL and testbench

SEG_READER -- requirements
Module: seg_reader

---
 rtl/seg_reader.sv | 159 +++++++++++++++
 tb/tb_seg_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_reader.sv
// Seven-segment scan reader: debounces multiplexed digit samples and presents full decoded frames.
// Optional macro SEG_READER_BLANK_EN: when defined, the all-off pattern decodes to code F (blank).

module seg_digit #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic       ok,
  input  logic [3:0] code,
  input  logic       clr,
  output logic [3:0] dig,
  output logic       mask,
  output logic       errb
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] SMAX   = CW'(STABLE_CNT);
  localparam logic [CW-1:0] SM1    = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam bit            SINGLE = (STABLE_CNT == 1);

  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          eq, commit;

  // Commit only on the transition into STABLE_CNT so a held digit does not re-arm the mask.
  always_comb begin
    eq     = (code == cand);
    commit = hit && ok && (eq ? (cnt == SM1) : SINGLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      dig  <= '0;
      mask <= 1'b0;
      errb <= 1'b0;
    end else begin
      if (clr) begin
        mask <= 1'b0;
        errb <= 1'b0;
      end
      if (hit) begin
        if (!ok) begin
          cand <= '0;
          cnt  <= '0;
          errb <= 1'b1;
        end else if (eq) begin
          if (cnt != SMAX) cnt <= cnt + ONE;
        end else begin
          cand <= code;
          cnt  <= ONE;
        end
      end
      // Placed after the frame clear so a same-cycle commit lands in the next frame.
      if (commit) begin
        dig  <= code;
        mask <= 1'b1;
      end
    end
  end
endmodule

module seg_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  sample,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     err,
  output logic                  out_valid,
  input  logic                  out_ready
);
  typedef enum logic {ACQ, PRESENT} state_t;

  localparam logic [DIGITS-1:0] ONE_D = DIGITS'(1);

  state_t                       state, nxt;
  logic [3:0]                   code;
  logic                         ok, sel_ok, hit, full, load;
  logic [DIGITS-1:0][3:0]       dig;
  logic [DIGITS-1:0]            mask, errb;

  always_comb begin
    code = 4'h0;
    ok   = 1'b1;
    case (seg)
      7'h3F: code = 4'h0;
      7'h06: code = 4'h1;
      7'h5B: code = 4'h2;
      7'h4F: code = 4'h3;
      7'h66: code = 4'h4;
      7'h6D: code = 4'h5;
      7'h7D: code = 4'h6;
      7'h07: code = 4'h7;
      7'h7F: code = 4'h8;
      7'h6F: code = 4'h9;
`ifdef SEG_READER_BLANK_EN
      7'h00: code = 4'hF;
`endif
      default: ok = 1'b0;
    endcase
  end

  assign sel_ok = (dig_sel != '0) && ((dig_sel & (dig_sel - ONE_D)) == '0);
  assign hit    = sample && sel_ok;
  assign full   = &mask;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg_digit #(.STABLE_CNT(STABLE_CNT)) u_dig (
      .clk  (clk),
      .rst_n(rst_n),
      .hit  (hit && dig_sel[g]),
      .ok   (ok),
      .code (code),
      .clr  (load),
      .dig  (dig[g]),
      .mask (mask[g]),
      .errb (errb[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACQ;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ACQ:     if (full)               nxt = PRESENT;
      PRESENT: if (out_ready && !full) nxt = ACQ;
      default:                         nxt = ACQ;
    endcase
  end

  // A full mask is taken whenever the output slot is free or being freed this cycle.
  always_comb begin
    load = full && ((state == ACQ) || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd <= '0;
      err <= '0;
    end else if (load) begin
      bcd <= dig;
      err <= errb;
    end
  end

  assign out_valid = (state == PRESENT);
endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: a frame-level reference model queues expected frames,
// a negedge monitor compares each presented frame until it is accepted.
module tb_seg_reader;
  localparam int D = 4;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst_n, sample, out_ready;
  logic [6:0]    seg;
  logic [D-1:0]  dig_sel;
  logic [4*D-1:0] bcd;
  logic [D-1:0]  err;
  logic          out_valid;

  int npass = 0, ntot = 0;

  seg_reader #(.DIGITS(D), .STABLE_CNT(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .sample(sample),
    .bcd(bcd), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference state: per-digit candidate/run length/committed code, frame mask, sticky errors.
  int          m_cand [D], m_cnt [D], m_dreg [D];
  bit          m_mask [D], m_eb [D];
  bit          mv;
  logic [19:0] sbq [$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
  endtask

  function automatic int dec(logic [6:0] s);
    for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
`ifdef SEG_READER_BLANK_EN
    if (s == 7'h00) return 15;
`endif
    return -1;
  endfunction

  task automatic model_step();
    bit full;
    int idx, c;
    logic [19:0] f;
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        m_cand[i] = 0; m_cnt[i] = 0; m_dreg[i] = 0; m_mask[i] = 0; m_eb[i] = 0;
      end
      mv = 0;
      sbq.delete();
      return;
    end
    full = 1;
    for (int i = 0; i < D; i++) if (!m_mask[i]) full = 0;
    if (full && (!mv || out_ready)) begin
      f = '0;
      for (int i = 0; i < D; i++) begin
        f[4*i +: 4] = 4'(m_dreg[i]);
        f[16 + i]   = m_eb[i];
        m_mask[i] = 0;
        m_eb[i]   = 0;
      end
      sbq.push_back(f);
      mv = 1;
    end else if (mv && out_ready) begin
      mv = 0;
    end
    if (sample && $countones(dig_sel) == 1) begin
      idx = 0;
      for (int i = 0; i < D; i++) if (dig_sel[i]) idx = i;
      c = dec(seg);
      if (c < 0) begin
        m_cand[idx] = 0; m_cnt[idx] = 0; m_eb[idx] = 1;
      end else if (c == m_cand[idx]) begin
        if (m_cnt[idx] < S) begin
          m_cnt[idx]++;
          if (m_cnt[idx] == S) begin m_dreg[idx] = c; m_mask[idx] = 1; end
        end
      end else begin
        m_cand[idx] = c; m_cnt[idx] = 1;
        if (S == 1) begin m_dreg[idx] = c; m_mask[idx] = 1; end
      end
    end
  endtask

  // Monitor first (current presentation), then advance the model across the coming edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        chk("frame", 32'({err, bcd}), 32'(sbq[0]));
        if (out_ready) void'(sbq.pop_front());
      end
    end
    model_step();
  end

  task automatic put(bit s, logic [D-1:0] d, logic [6:0] g);
    sample = s; dig_sel = d; seg = g;
    @(posedge clk); #2;
  endtask

  task automatic commit(int d, logic [6:0] g, int n);
    repeat (n) put(1'b1, D'(1 << d), g);
  endtask

  task automatic wait_frame(string nm, logic [19:0] exp);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid) seen = 1;
      else put(1'b0, '0, 7'h00);
    end
    chk({nm, "_seen"}, 32'(seen), 32'(1));
    if (seen) chk(nm, 32'({err, bcd}), 32'(exp));
  endtask

  logic [6:0] cur [D];
  int d;

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; sample = 1'b0; dig_sel = '0; seg = '0;
    put(0, '0, 0); put(0, '0, 0);
    chk("rst_outs", 32'({out_valid, err, bcd}), 32'(0));
    rst_n = 1'b1;

    // Basic frame 4321
    commit(0, 7'h06, 3); commit(1, 7'h5B, 3); commit(2, 7'h4F, 3); commit(3, 7'h66, 3);
    wait_frame("r027", {4'h0, 16'h4321});

    // Held frame while all digits recommit as 8, then back-to-back load
    for (int i = 0; i < D; i++) commit(i, 7'h7F, 3);
    repeat (8) put(0, '0, 0);
    chk("hold_valid", 32'(out_valid), 32'(1));
    chk("hold_frame", 32'({err, bcd}), 32'({4'h0, 16'h4321}));
    out_ready = 1'b1;
    put(0, '0, 0);
    chk("b2b_valid", 32'(out_valid), 32'(1));
    chk("b2b_frame", 32'({err, bcd}), 32'({4'h0, 16'h8888}));
    put(0, '0, 0);
    chk("drop_valid", 32'(out_valid), 32'(0));

    // Digit 2 settles on 5 after a short 6 run
    put(1, 4'b0100, 7'h7D); put(1, 4'b0100, 7'h7D);
    commit(2, 7'h6D, 3);
    commit(0, 7'h06, 3); commit(1, 7'h06, 3); commit(3, 7'h06, 3);
    wait_frame("r028", {4'h0, 16'h1511});

    // Invalid glitch on digit 1 leaves a sticky error in the frame
    put(1, 4'b0010, 7'h7E);
    commit(1, 7'h3F, 3);
    commit(0, 7'h5B, 3); commit(2, 7'h5B, 3); commit(3, 7'h5B, 3);
    wait_frame("r029", {4'b0010, 16'h2202});

    // Multi-hot and sample=0 are ignored; blank pattern handling
    put(1, 4'b0011, 7'h06);
    put(1, 4'b0001, 7'h00);
    put(1, 4'b0001, 7'h3F);
    put(1, 4'b0011, 7'h3F);
    put(0, 4'b0001, 7'h3F);
    put(1, 4'b0001, 7'h3F); put(1, 4'b0001, 7'h3F);
    commit(1, 7'h4F, 3); commit(2, 7'h4F, 3); commit(3, 7'h4F, 3);
`ifdef SEG_READER_BLANK_EN
    wait_frame("r031", {4'b0000, 16'h3330});
`else
    wait_frame("r031", {4'b0001, 16'h3330});
`endif
    put(0, '0, 0);

    // Reset mid-acquisition discards partial progress
    commit(0, 7'h66, 3); commit(1, 7'h66, 3);
    rst_n = 1'b0; put(0, '0, 0); rst_n = 1'b1;
    chk("r032_rst", 32'({out_valid, err, bcd}), 32'(0));
    commit(0, 7'h66, 3); commit(1, 7'h66, 3);
    repeat (3) put(0, '0, 0);
    chk("r032_partial", 32'(out_valid), 32'(0));
    commit(2, 7'h66, 3); commit(3, 7'h66, 3);
    wait_frame("r032", {4'h0, 16'h4444});

    // Random phase: sticky per-digit patterns that change occasionally
    for (int i = 0; i < D; i++) cur[i] = pat[$urandom_range(0, 9)];
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      out_ready = 1'($urandom_range(0, 1));
      d = $urandom_range(0, D - 1);
      if ($urandom_range(0, 19) == 0)
        cur[d] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : pat[$urandom_range(0, 9)];
      put($urandom_range(0, 9) < 7,
          ($urandom_range(0, 9) == 0) ? D'($urandom_range(0, 15)) : D'(1 << d),
          cur[d]);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) put(0, '0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
